// File: rtl/pipe_exe_em.sv
// rtl/pipe_exe_em.sv - execute stage ALU with EX/MEM pipeline register
// Reset and flush both leave MEM in a bubble so no write or memory access leaks downstream.
module pipe_exe_em #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             EM_W_ena,
  input  logic             flush,
  input  logic [WIDTH-1:0] EXE_pc4,
  input  logic [WIDTH-1:0] EXE_rs_reg,
  input  logic [WIDTH-1:0] EXE_rt_reg,
  input  logic [WIDTH-1:0] EXE_imm,
  input  logic [WIDTH-1:0] EXE_shamt,
  input  logic [3:0]       EXE_aluc,
  input  logic             EXE_aluc_mux1_select,
  input  logic [1:0]       EXE_aluc_mux2_select,
  input  logic             EXE_DMEM_ena,
  input  logic             EXE_DMEM_W_ena,
  input  logic [1:0]       EXE_DMEM_W,
  input  logic [1:0]       EXE_DMEM_R,
  input  logic [4:0]       EXE_RF_waddr,
  input  logic             EXE_RF_W_ena,
  input  logic             EXE_load_store_mux_select,
  input  logic [2:0]       EXE_RF_mux_select,
  output logic [WIDTH-1:0] EXE_fwd_data,
  output logic [4:0]       EXE_fwd_waddr,
  output logic             EXE_fwd_wena,
  output logic [WIDTH-1:0] MEM_alu_res,
  output logic [WIDTH-1:0] MEM_rt_reg,
  output logic [WIDTH-1:0] MEM_pc4,
  output logic             MEM_DMEM_ena,
  output logic             MEM_DMEM_W_ena,
  output logic [1:0]       MEM_DMEM_W,
  output logic [1:0]       MEM_DMEM_R,
  output logic [4:0]       MEM_RF_waddr,
  output logic             MEM_RF_W_ena,
  output logic             MEM_load_store_mux_select,
  output logic [2:0]       MEM_RF_mux_select,
  output logic             MEM_ovf
);

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [4:0]       sh;
  logic             ovf;

  always_comb begin
    op_a = EXE_aluc_mux1_select ? EXE_shamt : EXE_rs_reg;
    case (EXE_aluc_mux2_select)
      2'b00:   op_b = EXE_rt_reg;
      2'b01:   op_b = EXE_imm;
      2'b10:   op_b = EXE_pc4;
      default: op_b = '0;
    endcase
  end

  assign sum  = op_a + op_b;
  assign diff = op_a - op_b;
  assign sh   = op_a[4:0];

  always_comb begin
    alu_res = '0;
    casez (EXE_aluc)
      4'b00?0: alu_res = sum;
      4'b00?1: alu_res = diff;
      4'b0100: alu_res = op_a & op_b;
      4'b0101: alu_res = op_a | op_b;
      4'b0110: alu_res = op_a ^ op_b;
      4'b0111: alu_res = ~(op_a | op_b);
      4'b100?: alu_res = {op_b[15:0], 16'h0000};
      4'b1011: alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      4'b1010: alu_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
      4'b1100: alu_res = $signed(op_b) >>> sh;
      4'b1101: alu_res = op_b >> sh;
      default: alu_res = op_b << sh;
    endcase
  end

  // Only the trapping ADD/SUB encodings can flag overflow; the unsigned forms wrap silently.
  always_comb begin
    ovf = 1'b0;
    if (EXE_aluc == 4'b0010)
      ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
    else if (EXE_aluc == 4'b0011)
      ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
  end

  assign EXE_fwd_data  = alu_res;
  assign EXE_fwd_waddr = EXE_RF_waddr;
  assign EXE_fwd_wena  = EXE_RF_W_ena & ~ovf;

  always_ff @(posedge clk) begin
    if (!rst) begin
      MEM_alu_res               <= '0;
      MEM_rt_reg                <= '0;
      MEM_pc4                   <= '0;
      MEM_DMEM_ena              <= 1'b0;
      MEM_DMEM_W_ena            <= 1'b0;
      MEM_DMEM_W                <= '0;
      MEM_DMEM_R                <= '0;
      MEM_RF_waddr              <= '0;
      MEM_RF_W_ena              <= 1'b0;
      MEM_load_store_mux_select <= 1'b0;
      MEM_RF_mux_select         <= '0;
      MEM_ovf                   <= 1'b0;
    end else if (EM_W_ena) begin
      MEM_alu_res               <= alu_res;
      MEM_rt_reg                <= EXE_rt_reg;
      MEM_pc4                   <= EXE_pc4;
      MEM_DMEM_W                <= EXE_DMEM_W;
      MEM_DMEM_R                <= EXE_DMEM_R;
      MEM_RF_waddr              <= EXE_RF_waddr;
      MEM_load_store_mux_select <= EXE_load_store_mux_select;
      MEM_RF_mux_select         <= EXE_RF_mux_select;
      // A flush keeps the data fields but kills every side-effecting enable.
      MEM_DMEM_ena              <= EXE_DMEM_ena & ~flush;
      MEM_DMEM_W_ena            <= EXE_DMEM_W_ena & ~flush;
      MEM_RF_W_ena              <= EXE_RF_W_ena & ~ovf & ~flush;
      MEM_ovf                   <= ovf & ~flush;
    end
  end

endmodule

// File: doc/pipe_exe_em.md
Name: pipe_exe_em

Overview:
- Execute stage plus EX/MEM pipeline register, directly downstream of the decode-to-execute register.
- Consumes the EXE_* bundle: selects ALU operands, evaluates the 4-bit aluc operation and detects signed overflow.
- Registers the result and the memory/writeback control into the MEM_* bundle for the memory stage.
- Exposes the un-registered execute result and destination for the hazard/forwarding unit.

Parameters:
- WIDTH, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- EM_W_ena  in  1  register load enable; 0 holds all MEM_* outputs.
- flush  in  1  insert a bubble into MEM on this edge.
- EXE_pc4, EXE_rs_reg, EXE_rt_reg, EXE_imm, EXE_shamt  in  32 each  operands from the decode register.
- EXE_aluc  in  4  ALU opcode.
- EXE_aluc_mux1_select  in  1  operand A select: 0 = rs_reg, 1 = shamt.
- EXE_aluc_mux2_select  in  2  operand B select: 00 = rt_reg, 01 = imm, 10 = pc4, 11 = 0.
- EXE_DMEM_ena, EXE_DMEM_W_ena  in  1 each  data-memory enables.
- EXE_DMEM_W, EXE_DMEM_R  in  2 each  store/load size codes, passed through.
- EXE_RF_waddr  in  5  destination register.
- EXE_RF_W_ena  in  1  register-file write enable.
- EXE_load_store_mux_select  in  1  passed through.
- EXE_RF_mux_select  in  3  writeback source select, passed through.
- EXE_fwd_data  out  32  combinational ALU result of the current execute op.
- EXE_fwd_waddr  out  5  combinational; equals EXE_RF_waddr.
- EXE_fwd_wena  out  1  combinational; equals EXE_RF_W_ena AND NOT ovf.
- MEM_alu_res, MEM_rt_reg, MEM_pc4  out  32 each  registered.
- MEM_DMEM_ena, MEM_DMEM_W_ena  out  1 each  registered.
- MEM_DMEM_W, MEM_DMEM_R  out  2 each  registered.
- MEM_RF_waddr  out  5  registered.
- MEM_RF_W_ena  out  1  registered.
- MEM_load_store_mux_select  out  1  registered.
- MEM_RF_mux_select  out  3  registered.
- MEM_ovf  out  1  registered overflow flag.

Behaviour:
- Operand selection is combinational: A = mux1(rs_reg, shamt), B = mux2(rt_reg, imm, pc4, 0).
- aluc encoding:
  - 0000 ADDU: A+B.
  - 0010 ADD: A+B, signed overflow checked.
  - 0001 SUBU: A-B.
  - 0011 SUB: A-B, signed overflow checked.
  - 0100 AND, 0101 OR, 0110 XOR, 0111 NOR.
  - 100x LUI: {B[15:0], 16'h0}.
  - 1011 SLT: signed A<B, result is 1 or 0.
  - 1010 SLTU: unsigned A<B.
  - 1100 SRA: B>>>A[4:0].
  - 1101 SRL: B>>A[4:0].
  - 111x SLL: B<<A[4:0].
- Shift amounts use A[4:0] only; A[31:5] is ignored.
- Arithmetic wraps modulo 2^32.
- ovf = 1 only for ADD/SUB when the operand signs imply overflow:
  - ADD: A[31]==B[31] and result[31]!=A[31].
  - SUB: A[31]!=B[31] and result[31]!=A[31].
- When ovf=1, the write enable is suppressed in both EXE_fwd_wena and MEM_RF_W_ena. The result value is still registered.
- Latency is one cycle: execute inputs present at edge N appear on MEM_* after edge N.
- Edge priority (highest first):
  1. rst=0: all MEM_* outputs go to 0. This applies even if a hold or flush is in progress.
  2. EM_W_ena=0: every MEM_* output holds, including while flush=1.
  3. flush=1: bubble. MEM_DMEM_ena, MEM_DMEM_W_ena, MEM_RF_W_ena and MEM_ovf go to 0; data fields take the new values.
  4. Otherwise: load.
- On load:
  - MEM_alu_res = ALU result; MEM_rt_reg = EXE_rt_reg (store data); MEM_pc4 = EXE_pc4.
  - MEM_RF_W_ena = EXE_RF_W_ena AND NOT ovf; MEM_ovf = ovf.
  - All other controls are copied unchanged.
- The EXE_fwd_* outputs depend only on the EXE_* inputs; they ignore EM_W_ena, flush and rst.
- Reset state is a bubble, so no spurious write or memory access can occur after reset.

Test Plan:
- Reset: drive rst=0 for 2 edges with nonzero inputs -> every MEM_* output is 0. Release rst with ADDU 5+7 -> MEM_alu_res=12 after the next edge.
- Overflow: ADD with A=32'h7FFFFFFF, B=1, RF_W_ena=1 -> MEM_alu_res=32'h80000000, MEM_ovf=1, MEM_RF_W_ena=0, EXE_fwd_wena=0. The same operands with ADDU -> MEM_ovf=0, MEM_RF_W_ena=1.
- Shift and compare:
  - SRA with mux1=1, shamt=32'h24, B=32'h80000000 -> 32'hF8000000 (only bits [4:0] used, so shift=4).
  - SLT with A=-1, B=1 -> 1.
  - SLTU with A=-1, B=1 -> 0.
  - LUI with imm=32'h0000ABCD -> 32'hABCD0000.
- Hold/flush priority:
  - EM_W_ena=0 with flush=1 -> all MEM_* outputs unchanged.
  - Then EM_W_ena=1, flush=1, input store (DMEM_ena=1, DMEM_W_ena=1) -> MEM_DMEM_ena=0, MEM_DMEM_W_ena=0, MEM_RF_W_ena=0.
- Operand mux sweep: mux2 in 00/01/10/11 with rt=3, imm=4, pc4=32'h00400008, aluc ADDU, A=1 -> results 4, 5, 32'h00400009, 1.
- Mid-operation reset: assert rst=0 on the same edge as a valid load with EM_W_ena=1 -> outputs are 0, not the loaded values.
